mod_sysbus_mem_responder: RTL

//  Responder (memory) end of the Sysbus line-transfer protocol; the cache arbiter is the initiator.

---
 rtl/mod_sysbus_mem_responder_if.sv | 44 ++++
 rtl/mod_sysbus_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_sysbus_mem_responder_if.sv
// ---------------------------------------------------------------------------
// mod_sysbus_mem_responder_if
//
// Purpose:
//   Signal bundle for one Sysbus line-transfer link between an initiator
//   (cache arbiter / testbench) and a responder (memory).
//
// Signals:
//   req      initiator -> responder  address beat, then write data beats
//   reqtag   initiator -> responder  request tag (MSB = op, 1 = READ)
//   reqcyc   initiator -> responder  request beat valid
//   reqack   responder -> initiator  request beat accepted (one-cycle pulse)
//   resp     responder -> initiator  read data beat
//   resptag  responder -> initiator  tag of the transaction being answered
//   respcyc  responder -> initiator  response beat valid
//   respack  initiator -> responder  initiator accepts the response beat
//
// Modports:
//   master   initiator view
//   slave    responder view
// ---------------------------------------------------------------------------
interface mod_sysbus_mem_responder_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13
);
    logic [DATA_WIDTH-1:0] req;
    logic [TAG_WIDTH-1:0]  reqtag;
    logic                  reqcyc;
    logic                  reqack;
    logic [DATA_WIDTH-1:0] resp;
    logic [TAG_WIDTH-1:0]  resptag;
    logic                  respcyc;
    logic                  respack;

    modport master (
        output req, reqtag, reqcyc, respack,
        input  reqack, resp, resptag, respcyc
    );

    modport slave (
        input  req, reqtag, reqcyc, respack,
        output reqack, resp, resptag, respcyc
    );
endinterface

// File: rtl/mod_sysbus_mem_responder.sv
// ---------------------------------------------------------------------------
// mod_sysbus_mem_responder
//
// Purpose:
//   Memory (responder) end of the Sysbus line-transfer protocol. Each
//   transaction moves one 64-byte line (8 beats of 64 bits) between the
//   initiator and an internal word array. A write is an address beat
//   followed by 8 data beats; a read is an address beat answered by 8
//   response beats after a fixed latency.
//
// Parameters:
//   DATA_WIDTH    width of req/resp beats
//   TAG_WIDTH     width of reqtag/resptag; MSB is the op bit (1 = READ)
//   MEM_WORDS     depth of the backing array in words (multiple of 8)
//   READ_LATENCY  wait cycles before the first read beat (>= 1)
//
// Ports:
//   clk     clock
//   reset   synchronous, active-high reset
//   bus     Sysbus link, slave modport (req/reqtag/reqcyc/reqack,
//           resp/resptag/respcyc/respack)
//
// Build option:
//   MEMRESP_WRAP_FIRST_EN  when defined, read bursts start at word
//                          req[5:3] (critical word first) and wrap mod 8
//                          within the line. Writes always start at word 0.
//                          When undefined, reads return words 0..7.
//
// The array contents are not cleared by reset.
// ---------------------------------------------------------------------------
module mod_sysbus_mem_responder #(
    parameter int DATA_WIDTH   = 64,
    parameter int TAG_WIDTH    = 13,
    parameter int MEM_WORDS    = 4096,
    parameter int READ_LATENCY = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    mod_sysbus_mem_responder_if.slave   bus
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int LINE_W = IDX_W - 3;
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_DATA  = 2'd1,
        RD_WAIT  = 2'd2,
        RD_BURST = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // control state
    state_t                state_q,    state_d;
    logic [2:0]            beat_cnt_q, beat_cnt_d;
    logic [LAT_W-1:0]      lat_cnt_q,  lat_cnt_d;
    logic                  reqack_q,   reqack_d;
    logic [DATA_WIDTH-1:0] resp_q,     resp_d;
    logic [TAG_WIDTH-1:0]  resptag_q,  resptag_d;
    logic                  respcyc_q,  respcyc_d;

    // transaction context, only meaningful while a transaction is open
    logic [TAG_WIDTH-1:0]  tag_q,   tag_d;
    logic [LINE_W-1:0]     line_q,  line_d;
    logic [2:0]            start_q, start_d;

    logic                  accept;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_waddr;
    logic [2:0]            rd_beat;

    logic [IDX_W-1:0]      req_word;
    logic [IDX_W-1:0]      req_word_mod;
    logic [LINE_W-1:0]     req_line;
    logic                  unused_bits;

    // Line index from the byte address. The modulo keeps the index inside
    // the array for any depth that is a multiple of 8; for power-of-two
    // depths it reduces to plain bit truncation.
    always_comb begin
        req_word     = bus.req[3 +: IDX_W];
        req_word_mod = IDX_W'(32'(req_word) % 32'(MEM_WORDS));
        req_line     = req_word_mod[IDX_W-1:3];
    end

    assign unused_bits = ^{bus.req[DATA_WIDTH-1:IDX_W+3], bus.req[2:0], req_word_mod[2:0]};

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        resp_d     = resp_q;
        resptag_d  = resptag_q;
        respcyc_d  = respcyc_q;
        tag_d      = tag_q;
        line_d     = line_q;
        start_d    = start_q;
        accept     = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = {line_q, beat_cnt_q};
        rd_beat    = start_q;

        case (state_q)
            IDLE: begin
                // A beat is never taken while reqack is high: req still
                // holds the beat that was just accepted.
                accept = bus.reqcyc && !reqack_q;
                if (accept) begin
                    tag_d      = bus.reqtag;
                    line_d     = req_line;
                    beat_cnt_d = 3'd0;
                    lat_cnt_d  = '0;
`ifdef MEMRESP_WRAP_FIRST_EN
                    start_d    = bus.req[5:3];
`else
                    start_d    = 3'd0;
`endif
                    state_d    = bus.reqtag[TAG_WIDTH-1] ? RD_WAIT : WR_DATA;
                end
            end

            WR_DATA: begin
                accept = bus.reqcyc && !reqack_q;
                if (accept) begin
                    mem_we     = 1'b1;
                    beat_cnt_d = beat_cnt_q + 3'd1;
                    if (beat_cnt_q == 3'd7) begin
                        state_d = IDLE;
                    end
                end
            end

            RD_WAIT: begin
                // lat_cnt runs 0..READ_LATENCY; the final step loads the
                // first word into the beat register, so beat 0 appears
                // READ_LATENCY+1 cycles after the address-accept edge.
                if (lat_cnt_q == LAT_W'(READ_LATENCY)) begin
                    state_d   = RD_BURST;
                    respcyc_d = 1'b1;
                    resptag_d = tag_q;
                    rd_beat   = start_q;
                    resp_d    = mem[{line_q, rd_beat}];
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end

            RD_BURST: begin
                // Without respack every output simply holds.
                if (respcyc_q && bus.respack) begin
                    if (beat_cnt_q == 3'd7) begin
                        state_d    = IDLE;
                        respcyc_d  = 1'b0;
                        resp_d     = '0;
                        resptag_d  = '0;
                        beat_cnt_d = 3'd0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 3'd1;
                        // 3-bit sum wraps within the line
                        rd_beat    = start_q + beat_cnt_q + 3'd1;
                        resp_d     = mem[{line_q, rd_beat}];
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        reqack_d = accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= 3'd0;
            lat_cnt_q  <= '0;
            reqack_q   <= 1'b0;
            resp_q     <= '0;
            resptag_q  <= '0;
            respcyc_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            reqack_q   <= reqack_d;
            resp_q     <= resp_d;
            resptag_q  <= resptag_d;
            respcyc_q  <= respcyc_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q   <= tag_d;
        line_q  <= line_d;
        start_q <= start_d;
    end

    // A reset edge abandons any write beat arriving on that same edge.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= bus.req;
        end
    end

    assign bus.reqack  = reqack_q;
    assign bus.resp    = resp_q;
    assign bus.resptag = resptag_q;
    assign bus.respcyc = respcyc_q;

endmodule
